// File: rtl/transpose_checker.sv
// transpose_checker: scans the source buffer Ai and the result buffer Co through
// two 1-cycle-latency read ports, verifies Co[i*DIM+j] == Ai[j*DIM+i] for every
// element, counts mismatches, latches the first failing Co address and reports
// pass/fail with a single-cycle done pulse.
module transpose_checker #(
    parameter int WIDTH  = 32,
    parameter int DIM    = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    input  logic [WIDTH-1:0]  a_rd_data,
    output logic              c_rd_en,
    output logic [ADDR_W-1:0] c_rd_addr,
    input  logic [WIDTH-1:0]  c_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int LOG2_DIM = $clog2(DIM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  k;          // issue counter, doubles as the Co address
    logic               rd_en_q;
    logic               cmp_valid;  // read data returning this cycle belongs to cmp_addr
    logic [ADDR_W-1:0]  cmp_addr;
    logic               mismatch;
    logic [ADDR_W:0]    err_next;

    // Both ports are read in lockstep; Ai is addressed with row/column fields swapped.
    assign a_rd_en   = rd_en_q;
    assign c_rd_en   = rd_en_q;
    assign c_rd_addr = k;
    assign a_rd_addr = {k[LOG2_DIM-1:0], k[ADDR_W-1:LOG2_DIM]};

    // Compare the returning pair and form the error count including this cycle's result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mismatch = 1'b0;
        err_next = err_count;
        if (cmp_valid && (a_rd_data != c_rd_data)) begin
            mismatch = 1'b1;
            err_next = err_count + (ADDR_W+1)'(1);
        end
    end

    // Control FSM with registered outputs and the compare-stage bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state           <= ST_IDLE;
            k               <= '0;
            rd_en_q         <= 1'b0;
            cmp_valid       <= 1'b0;
            cmp_addr        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            done      <= 1'b0;
            cmp_valid <= 1'b0;

            if (mismatch) begin
                err_count <= err_next;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= cmp_addr;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state           <= ST_SCAN;
                        k               <= '0;
                        rd_en_q         <= 1'b1;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                    end
                end
                ST_SCAN: begin
                    cmp_valid <= 1'b1;
                    cmp_addr  <= k;
                    if (k == '1) begin
                        // Last element issued: stop reading, hold k (no second pass).
                        state   <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        k <= k + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Final element is compared this cycle; pass must see its result.
                    state <= ST_DONE;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
